// File: rtl/whack_pkg.sv
// whack_pkg: state encoding and timing tables for the mole scheduler.
// Difficulty tables are indexed 0 (easy) .. 3 (hardest), values in ms.
package whack_pkg;

   localparam int NUM_HOLES_DEF = 4;
   localparam int MS_W = 11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GAP  = 2'd1,
      S_UP   = 2'd2,
      S_HIT  = 2'd3
   } state_t;

   localparam logic [3:0][MS_W-1:0] GAP_MS =
      {11'd200, 11'd300, 11'd400, 11'd500};
   localparam logic [3:0][MS_W-1:0] UP_MS =
      {11'd400, 11'd600, 11'd900, 11'd1200};
   localparam logic [MS_W-1:0] HIT_MS = 11'd150;

endpackage

// File: rtl/whack_lfsr.sv
// whack_lfsr: 8-bit Fibonacci LFSR, taps 8,6,5,4 (maximal length).
// Steps once per clock while en is high; exposes the two low bits.
module whack_lfsr #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic [1:0] rnd
);

   logic [7:0] q;
   logic       fb;

   assign fb  = q[7] ^ q[5] ^ q[4] ^ q[3];
   assign rnd = q[1:0];

   // Shift register; a nonzero seed keeps it out of the lock-up state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= SEED;
      else if (en) q <= {q[6:0], fb};
   end

endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: pops one mole at a time, times it, reports hit/miss.
// Define WHACK_PENALTY_EN to pulse penalty_pulse on wrong-hole presses.
module mole_scheduler
   import whack_pkg::*;
#(
   parameter int         NUM_HOLES = NUM_HOLES_DEF,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 tick_ms,
   input  logic [1:0]           difficulty,
   input  logic [NUM_HOLES-1:0] hit_btn,
   output logic [NUM_HOLES-1:0] mole_led,
   output logic                 score_inc,
   output logic                 miss_pulse,
   output logic                 penalty_pulse
);

   state_t               state_q, state_d;
   logic [MS_W-1:0]      cnt_q, lim;
   logic [1:0]           diff_q, hole_q, hole_d, rnd, pick;
   logic                 last_tick, hit;
   logic [NUM_HOLES-1:0] oh_q, led_d;
   logic                 score_d, miss_d;

   whack_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (enable),
      .rnd   (rnd)
   );

   assign oh_q = {{(NUM_HOLES-1){1'b0}}, 1'b1} << hole_q;
   assign pick = (rnd == hole_q) ? rnd + 2'd1 : rnd;
   assign hit  = (state_q == S_UP) && hit_btn[hole_q];
   assign last_tick = tick_ms && (cnt_q == lim - 11'd1);

   // Duration of the current state; gap follows the live difficulty
   always_comb begin
      lim = HIT_MS;
      unique case (1'b1)
         state_q == S_GAP: lim = GAP_MS[difficulty];
         state_q == S_UP:  lim = UP_MS[diff_q];
         default:          lim = HIT_MS;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next state; dropping enable forces idle from anywhere
   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: state_d = S_GAP;
            S_GAP:  if (last_tick) state_d = S_UP;
            S_UP: begin
               if (hit)            state_d = S_HIT;
               else if (last_tick) state_d = S_GAP;
            end
            S_HIT:  if (last_tick) state_d = S_GAP;
         endcase
      end
   end

   // Output decode, one cycle ahead of the registered outputs
   always_comb begin
      hole_d = hole_q;
      if (state_q == S_GAP && state_d == S_UP) hole_d = pick;
      led_d = '0;
      if (state_d == S_UP) led_d[hole_d] = 1'b1;
      score_d = (state_q == S_UP) && (state_d == S_HIT);
      miss_d  = (state_q == S_UP) && (state_d == S_GAP);
   end

   // Ms counter, cleared on every state change and while idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (state_d != state_q || state_q == S_IDLE)
         cnt_q <= '0;
      else if (tick_ms)
         cnt_q <= cnt_q + 11'd1;
   end

   // Hole and difficulty captured when a mole pops up
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hole_q <= 2'd0;
         diff_q <= 2'd0;
      end else if (state_q == S_GAP && state_d == S_UP) begin
         hole_q <= hole_d;
         diff_q <= difficulty;
      end
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mole_led   <= '0;
         score_inc  <= 1'b0;
         miss_pulse <= 1'b0;
      end else begin
         mole_led   <= led_d;
         score_inc  <= score_d;
         miss_pulse <= miss_d;
      end
   end

`ifdef WHACK_PENALTY_EN
   logic pen_d;

   assign pen_d = enable && (state_q == S_UP) && !hit &&
                  (|(hit_btn & ~oh_q));

   // Wrong-hole press in UP, suppressed when the right hole is also hit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) penalty_pulse <= 1'b0;
      else        penalty_pulse <= pen_d;
   end
`else
   assign penalty_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: directed + random stimulus against a ms-level model.
// Model tracks phase and elapsed ms per game rules, predicts every output.
module tb_mole_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       tick_ms = 1'b0;
   logic [1:0] difficulty = 2'd0;
   logic [3:0] hit_btn = 4'd0;
   logic [3:0] mole_led;
   logic       score_inc, miss_pulse, penalty_pulse;

   int checks = 0;
   int errors = 0;

`ifdef WHACK_PENALTY_EN
   localparam bit PEN_EN = 1'b1;
`else
   localparam bit PEN_EN = 1'b0;
`endif

   localparam int M_IDLE = 0;
   localparam int M_GAP  = 1;
   localparam int M_UP   = 2;
   localparam int M_HIT  = 3;

   int gap_tab [4] = '{500, 400, 300, 200};
   int up_tab  [4] = '{1200, 900, 600, 400};

   int         m_mode = M_IDLE;
   int         m_ms = 0;
   logic [1:0] m_hole = 2'd0;
   logic [1:0] m_diff = 2'd0;
   logic [7:0] m_lfsr = 8'hA5;
   logic [3:0] e_led = 4'd0;
   bit         e_score, e_miss, e_pen;

   logic [3:0] prev_led = 4'd0;
   logic [3:0] last_mole = 4'b0001;
   int         moles = 0;

   mole_scheduler dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .tick_ms       (tick_ms),
      .difficulty    (difficulty),
      .hit_btn       (hit_btn),
      .mole_led      (mole_led),
      .score_inc     (score_inc),
      .miss_pulse    (miss_pulse),
      .penalty_pulse (penalty_pulse)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE;
      m_ms = 0;
      m_hole = 2'd0;
      m_diff = 2'd0;
      m_lfsr = 8'hA5;
      e_led = 4'd0;
      prev_led = 4'd0;
      last_mole = 4'b0001;
   endtask

   // Predicts what the outputs show after the coming clock edge
   task automatic model_edge(input bit en, input bit tk,
                             input logic [1:0] d, input logic [3:0] btn);
      logic [1:0] r;
      e_score = 1'b0;
      e_miss = 1'b0;
      e_pen = 1'b0;
      if (!en) begin
         m_mode = M_IDLE;
      end else begin
         case (m_mode)
            M_IDLE: begin
               m_mode = M_GAP;
               m_ms = 0;
            end
            M_GAP: begin
               m_ms += int'(tk);
               if (m_ms == gap_tab[d]) begin
                  r = m_lfsr[1:0];
                  m_hole = (r == m_hole) ? r + 2'd1 : r;
                  m_diff = d;
                  m_mode = M_UP;
                  m_ms = 0;
               end
            end
            M_UP: begin
               if (btn[m_hole]) begin
                  e_score = 1'b1;
                  m_mode = M_HIT;
                  m_ms = 0;
               end else begin
                  e_pen = PEN_EN && (btn != 4'd0);
                  m_ms += int'(tk);
                  if (m_ms == up_tab[m_diff]) begin
                     e_miss = 1'b1;
                     m_mode = M_GAP;
                     m_ms = 0;
                  end
               end
            end
            default: begin
               m_ms += int'(tk);
               if (m_ms == 150) begin
                  m_mode = M_GAP;
                  m_ms = 0;
               end
            end
         endcase
         m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      end
      e_led = (m_mode == M_UP) ? (4'b0001 << m_hole) : 4'd0;
   endtask

   task automatic step(input bit en, input bit tk,
                       input logic [1:0] d, input logic [3:0] btn);
      enable = en;
      tick_ms = tk;
      difficulty = d;
      hit_btn = btn;
      model_edge(en, tk, d, btn);
      @(posedge clk);
      #1;
      chk("mole_led", mole_led, e_led);
      chk("score_inc", score_inc, e_score);
      chk("miss_pulse", miss_pulse, e_miss);
      chk("penalty_pulse", penalty_pulse, e_pen);
      if (mole_led != 4'd0 && prev_led == 4'd0) begin
         moles++;
         chk("no_repeat", mole_led != last_mole, 1);
         last_mole = mole_led;
      end
      prev_led = mole_led;
      tick_ms = 1'b0;
      hit_btn = 4'd0;
   endtask

   task automatic run_to_led(input logic [1:0] d, output int n);
      n = 0;
      while (mole_led == 4'd0 && n < 3000) begin
         step(1'b1, 1'b1, d, 4'd0);
         n++;
      end
   endtask

   initial begin
      int n;
      bit en_r;
      bit tk;
      logic [1:0] d_r;
      logic [3:0] b;

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_led", mole_led, 0);
      chk("rst_score", score_inc, 0);
      chk("rst_miss", miss_pulse, 0);
      chk("rst_pen", penalty_pulse, 0);
      rst_n = 1'b1;
      step(1'b0, 1'b1, 2'd0, 4'hF);

      // Easy game, no presses: 500 ms gap then 1200 ms timeout
      step(1'b1, 1'b0, 2'd0, 4'd0);
      run_to_led(2'd0, n);
      chk("A_gap_ticks", n, 500);
      n = 0;
      while (!miss_pulse && n < 3000) begin
         step(1'b1, 1'b1, 2'd0, 4'd0);
         n++;
      end
      chk("A_up_ticks", n, 1200);
      chk("A_led_off", mole_led, 0);

      // Hardest: hit on tick 100, 150 ms dark, 200 ms gap
      run_to_led(2'd3, n);
      chk("B_gap_ticks", n, 200);
      repeat (99) step(1'b1, 1'b1, 2'd3, 4'd0);
      step(1'b1, 1'b1, 2'd3, 4'b0001 << m_hole);
      chk("B_score", score_inc, 1);
      chk("B_led_off", mole_led, 0);
      run_to_led(2'd3, n);
      chk("B_dark_ticks", n, 350);

      // Hit on the very tick the mole would time out
      repeat (399) step(1'b1, 1'b1, 2'd3, 4'd0);
      step(1'b1, 1'b1, 2'd3, 4'b0001 << m_hole);
      chk("C_score", score_inc, 1);
      chk("C_miss", miss_pulse, 0);

      // Wrong hole, then wrong and right together
      run_to_led(2'd3, n);
      repeat (5) step(1'b1, 1'b1, 2'd3, 4'd0);
      step(1'b1, 1'b1, 2'd3, 4'b0001 << (m_hole + 2'd1));
      chk("D_pen", penalty_pulse, PEN_EN);
      chk("D_lit", mole_led, 4'b0001 << m_hole);
      step(1'b1, 1'b1, 2'd3, 4'd0);
      chk("D_pen_width", penalty_pulse, 0);
      step(1'b1, 1'b1, 2'd3,
           (4'b0001 << m_hole) | (4'b0001 << (m_hole + 2'd1)));
      chk("D_both_score", score_inc, 1);
      chk("D_both_pen", penalty_pulse, 0);

      // Enable dropped mid-UP
      run_to_led(2'd3, n);
      repeat (5) step(1'b1, 1'b1, 2'd3, 4'd0);
      step(1'b0, 1'b1, 2'd3, 4'b0001 << m_hole);
      chk("E_led", mole_led, 0);
      chk("E_score", score_inc, 0);
      chk("E_miss", miss_pulse, 0);
      repeat (3) step(1'b0, 1'b1, 2'd3, 4'd0);

      // Asynchronous reset while a mole is lit
      step(1'b1, 1'b0, 2'd2, 4'd0);
      run_to_led(2'd2, n);
      repeat (3) step(1'b1, 1'b1, 2'd2, 4'd0);
      rst_n = 1'b0;
      enable = 1'b0;
      #1;
      chk("R_led_async", mole_led, 0);
      chk("R_score", score_inc, 0);
      chk("R_miss", miss_pulse, 0);
      chk("R_pen", penalty_pulse, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("R_led_hold", mole_led, 0);
      rst_n = 1'b1;

      // Random play: ticks, presses, enable drops, per-game difficulty
      moles = 0;
      en_r = 1'b0;
      d_r = 2'($urandom_range(0, 3));
      for (int c = 0; c < 60000 && moles < 50; c++) begin
         if (en_r && $urandom_range(0, 2999) == 0)
            en_r = 1'b0;
         else if (!en_r && $urandom_range(0, 3) == 0)
            en_r = 1'b1;
         if (!en_r) d_r = 2'($urandom_range(0, 3));
         tk = ($urandom_range(0, 7) != 0);
         b = 4'd0;
         if (m_mode == M_UP) begin
            if ($urandom_range(0, 39) == 0)
               b = 4'($urandom_range(1, 15));
         end else if ($urandom_range(0, 19) == 0) begin
            b = 4'($urandom_range(1, 15));
         end
         step(en_r, tk, d_r, b);
      end
      chk("rand_moles", moles >= 20, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mole_scheduler.md
MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 SHALL have parameter NUM_HOLES, default 4, number of mole holes/buttons (fixed at 4 in this release).
REQ-002 SHALL have parameter LFSR_SEED, default 8'hA5, nonzero LFSR reset value.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  level; high while the game is in PLAYING.
REQ-006 SHALL have port tick_ms  input  1  one-cycle pulse every 1 ms.
REQ-007 SHALL have port difficulty  input  2  0=easy … 3=hardest.
REQ-008 SHALL have port hit_btn  input  4  one-cycle debounced button pulses, bit i = hole i.
REQ-009 SHALL have port mole_led  output  4  one-hot active mole (all zero when none).
REQ-010 SHALL have port score_inc  output  1  one-cycle pulse per successful hit.
REQ-011 SHALL have port miss_pulse  output  1  one-cycle pulse when a mole times out unhit.
REQ-012 SHALL have port penalty_pulse  output  1  one-cycle pulse on wrong-hole press (see Configuration).

Function
REQ-013 SHALL implement states IDLE, GAP, UP, HIT_SHOW; all outputs registered.
REQ-014 IDLE: mole_led=0; on enable=1 go to GAP with ms counter cleared.
REQ-015 GAP: mole_led=0; after gap_ms tick_ms pulses go to UP; gap_ms = 500/400/300/200 for difficulty 0/1/2/3.
REQ-016 On GAP->UP, SHALL latch difficulty and pick hole = lfsr[1:0]; if equal to previous hole, use (lfsr[1:0]+1) mod 4.
REQ-017 UP: mole_led = one-hot(hole); up_ms = 1200/900/600/400 for difficulty 0/1/2/3, using the value latched at entry.
REQ-018 UP, hit_btn[hole]=1: score_inc pulses next cycle, go to HIT_SHOW.
REQ-019 UP, counter reaches up_ms with no hit: miss_pulse pulses next cycle, go to GAP.
REQ-020 Hit and timeout in same cycle: hit wins, no miss_pulse.
REQ-021 HIT_SHOW: mole_led=0 for 150 ms, further presses ignored, then GAP.
REQ-022 Presses in IDLE, GAP, HIT_SHOW SHALL produce no pulses.
REQ-023 Ms counter 11 bits, cleared on every state entry, increments only on tick_ms; pulses SHALL never be more than one cycle wide.
REQ-024 LFSR: 8-bit Fibonacci, taps 8,6,5,4, advances every clk while enable=1; never zero.
REQ-025 enable falling in any state: next cycle state=IDLE, mole_led=0, no pulses; previous-hole memory retained.

Reset
REQ-026 On rst_n low: state=IDLE, mole_led=0, score_inc=miss_pulse=penalty_pulse=0, counter=0, lfsr=LFSR_SEED, previous hole=0.
REQ-027 Reset assertion mid-UP SHALL drop mole_led immediately (asynchronous) with no pulse emitted.

Configuration
REQ-028 With WHACK_PENALTY_EN defined: in UP, any hit_btn bit other than hole set without hit_btn[hole] gives penalty_pulse one cycle later; state unchanged.
REQ-029 Correct and wrong bits in same cycle: counted as hit only, no penalty.
REQ-030 Without WHACK_PENALTY_EN: penalty_pulse tied 0, no wrong-press logic.

Structure
REQ-031 Shared package whack_pkg SHALL hold state encoding, gap/up/hit-show ms constant tables indexed by difficulty, and NUM_HOLES default.
REQ-032 SHALL instantiate one sub-module whack_lfsr (8-bit LFSR, enable, seed parameter).

Verification
REQ-033 Reset, enable=1, difficulty=0, no presses -> mole_led nonzero after 500 ticks; miss_pulse after further 1200 ticks; mole_led=0.
REQ-034 difficulty=3, press correct hole at tick 100 of UP -> score_inc one cycle, mole_led=0 for 150 ticks, next mole after 200-tick gap.
REQ-035 Correct press on the same cycle as the 400th UP tick (difficulty 3) -> score_inc=1, miss_pulse=0.
REQ-036 WHACK_PENALTY_EN defined, wrong hole pressed in UP -> penalty_pulse one cycle, mole stays lit; correct+wrong same cycle -> score_inc only.
REQ-037 enable dropped mid-UP -> mole_led=0 and state IDLE next cycle, no pulses; 1000 consecutive moles never repeat hole back-to-back.
